// File: rtl/sram_row_ctrl_pkg.sv
// Shared definitions for the bitcell row sequencer: FSM state encoding and default geometry.
package sram_row_ctrl_pkg;

    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ACC_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Width of the ACCESS-cycle counter; never zero, even for a single-cycle access.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_row_dec.sv
// Registered ADDR_W -> 2**ADDR_W one-hot word-select decoder with enable; outputs clear asynchronously on reset.
module sram_row_dec #(
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(1<<ADDR_W)-1:0] row_sel
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_sel <= '0;
        end else begin
            row_sel <= '0;
            if (en) row_sel[addr] <= 1'b1;
        end
    end

endmodule

// File: rtl/sram_row_ctrl.sv
// Request sequencer for the NAND-latch bitcell array: IDLE -> SETUP -> ACCESS -> RECOVER.
// Define SRAM_CTRL_READBACK_EN to verify every write with a read of the same row.
module sram_row_ctrl
    import sram_row_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_CYCLES = DEF_ACC_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [(1<<ADDR_W)-1:0] row_sel,
    output logic                   r_w,
    output logic [DATA_W-1:0]      bit_in,
    input  logic [DATA_W-1:0]      col_out
);

    localparam int CNT_W = cnt_width(ACC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

    state_t            state, nxt_state;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic              nxt_rw;
    logic [DATA_W-1:0] nxt_bit_in;
    logic              sel_en;
    logic              capture;
    logic              respond;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;

`ifdef SRAM_CTRL_READBACK_EN
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rb_q, nxt_rb;
    logic              rsp_err_q;
`endif

    assign accept = (state == ST_IDLE) && req_valid && req_ready;

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_rw     = r_w;
        nxt_bit_in = bit_in;
        sel_en     = 1'b0;
        capture    = 1'b0;
        respond    = 1'b0;
`ifdef SRAM_CTRL_READBACK_EN
        nxt_rb     = rb_q;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt_state  = ST_SETUP;
                    nxt_rw     = req_we;
                    nxt_bit_in = req_we ? req_wdata : '0;
`ifdef SRAM_CTRL_READBACK_EN
                    nxt_rb     = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                nxt_state = ST_ACCESS;
                sel_en    = 1'b1;
                nxt_cnt   = '0;
            end
            ST_ACCESS: begin
                // Leaving the last ACCESS cycle: sel drops and read data is sampled on the same edge.
                if (cnt == CNT_LAST) begin
                    nxt_state = ST_RECOVER;
                    capture   = !r_w;
`ifdef SRAM_CTRL_READBACK_EN
                    respond   = !r_w || rb_q;
`else
                    respond   = 1'b1;
`endif
                end else begin
                    sel_en  = 1'b1;
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                nxt_state = ST_IDLE;
`ifdef SRAM_CTRL_READBACK_EN
                if (we_q && !rb_q) begin
                    nxt_state  = ST_SETUP;
                    nxt_rw     = 1'b0;
                    nxt_bit_in = '0;
                    nxt_rb     = 1'b1;
                end
`endif
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            r_w       <= 1'b0;
            bit_in    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            r_w       <= nxt_rw;
            bit_in    <= nxt_bit_in;
            req_ready <= (nxt_state == ST_IDLE);
            rsp_valid <= respond;
            if (capture) rsp_rdata <= col_out;
        end
    end

    // Request fields are pure data: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= req_addr;
`ifdef SRAM_CTRL_READBACK_EN
            we_q    <= req_we;
            wdata_q <= req_wdata;
`endif
        end
    end

`ifdef SRAM_CTRL_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_q      <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            rb_q <= nxt_rb;
            if (respond) rsp_err_q <= capture && rb_q && (col_out != wdata_q);
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    sram_row_dec #(
        .ADDR_W (ADDR_W)
    ) u_row_dec (
        .clk     (clk),
        .rst     (rst),
        .en      (sel_en),
        .addr    (addr_q),
        .row_sel (row_sel)
    );

endmodule

// File: tb/tb_sram_row_ctrl.sv
// Directed bench for sram_row_ctrl with a behavioural bitcell array; follows SRAM_CTRL_READBACK_EN if defined.
module tb_sram_row_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int ACC    = 2;
    localparam int ROWS   = 1 << ADDR_W;
`ifdef SRAM_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ROWS-1:0]   row_sel;
    logic              r_w;
    logic [DATA_W-1:0] bit_in;
    logic [DATA_W-1:0] col_out;

    logic [DATA_W-1:0] mem [ROWS];
    logic              mem_clr;
    logic              stuck0;
    logic              mon_en;
    logic [ROWS-1:0]   prev_sel;
    logic              prev_rw;
    logic [DATA_W-1:0] prev_bin;
    int                seq_viol;
    int                tests;
    int                fails;

    sram_row_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ACC_CYCLES (ACC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .row_sel   (row_sel),
        .r_w       (r_w),
        .bit_in    (bit_in),
        .col_out   (col_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bitcell array: selected row latches bit_in while r_w=1; out lines are the OR of selected rows.
    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (mem_clr) mem[r] <= '0;
            else if (row_sel[r] && r_w) mem[r] <= bit_in;
        end
    end

    always_comb begin
        col_out = '0;
        for (int r = 0; r < ROWS; r++)
            if (row_sel[r]) col_out = col_out | mem[r];
        if (stuck0) col_out[0] = 1'b0;
    end

    // Any cycle with sel high, or just after sel was high, must see r_w/bit_in unchanged; sel never multi-hot.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((row_sel != '0 || prev_sel != '0) && (r_w != prev_rw || bit_in != prev_bin))
                seq_viol = seq_viol + 1;
            if ($countones(row_sel) > 1)
                seq_viol = seq_viol + 1;
        end
        prev_sel = row_sel;
        prev_rw  = r_w;
        prev_bin = bit_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request from an idle negedge and follow it to its response; ends on an idle negedge.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                          input logic [DATA_W-1:0] exp_rd, input logic exp_err);
        int              lat;
        int              exp_lat;
        int              ph;
        logic [ROWS-1:0] exp_sel;
        exp_lat = (we && RB) ? 2 * (ACC + 2) : ACC + 2;
        exp_sel = ROWS'(1) << addr;
        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wd;
        check("setup_sel", 32'(row_sel), 32'd0);
        check("setup_rw", 32'(r_w), 32'(we));
        check("setup_bit_in", 32'(bit_in), 32'(we ? wd : 8'h00));
        check("busy_ready", 32'(req_ready), 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
            if (!rsp_valid) begin
                ph = (lat - 2) % (ACC + 2);
                check("access_sel", 32'(row_sel), (ph < ACC) ? 32'(exp_sel) : 32'd0);
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_sel_low", 32'(row_sel), 32'd0);
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        @(negedge clk);
        check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
    } vec_t;

    vec_t vecs [10];
    int   acc_n;
    int   rsp_n;
    int   acc_second;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tests     = 0;
        fails     = 0;
        seq_viol  = 0;
        mon_en    = 1'b0;
        stuck0    = 1'b0;
        mem_clr   = 1'b1;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Writes keep the last read data unless the readback path recaptures the row.
        vecs[0] = '{1'b1, 4'd3,  8'hA5, RB ? 8'hA5 : 8'h00, 1'b0};
        vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5,              1'b0};
        vecs[2] = '{1'b1, 4'd0,  8'hFF, RB ? 8'hFF : 8'hA5, 1'b0};
        vecs[3] = '{1'b1, 4'd15, 8'h00, RB ? 8'h00 : 8'hA5, 1'b0};
        vecs[4] = '{1'b0, 4'd0,  8'h00, 8'hFF,              1'b0};
        vecs[5] = '{1'b0, 4'd15, 8'h00, 8'h00,              1'b0};
        vecs[6] = '{1'b1, 4'd7,  8'h3C, RB ? 8'h3C : 8'h00, 1'b0};
        vecs[7] = '{1'b0, 4'd7,  8'h00, 8'h3C,              1'b0};
        vecs[8] = '{1'b0, 4'd3,  8'h00, 8'hA5,              1'b0};
        vecs[9] = '{1'b0, 4'd1,  8'h00, 8'h00,              1'b0};

        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_sel", 32'(row_sel), 32'd0);
        check("rst_rw", 32'(r_w), 32'd0);
        check("rst_bit_in", 32'(bit_in), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        rst     = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++)
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);

        // Reset during the first ACCESS cycle of a write to row 5.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd5;
        req_wdata = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_access_sel", 32'(row_sel), 32'h0020);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(row_sel), 32'd0);
        check("async_rst_rw", 32'(r_w), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_sel", 32'(row_sel), 32'd0);
        check("post_rst_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk);
        mon_en = 1'b1;
        do_req(1'b0, 4'd0, 8'h00, 8'hFF, 1'b0);
        do_req(1'b0, 4'd7, 8'h00, 8'h3C, 1'b0);

        // req_valid held for 10 cycles of reads: accepts in cycles 0 and 5 only.
        acc_n      = 0;
        rsp_n      = 0;
        acc_second = -1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 4'd3;
        for (int c = 0; c < 18; c++) begin
            if (c == 10) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                acc_n++;
                if (acc_n == 2) acc_second = c;
            end
            if (rsp_valid) rsp_n++;
            @(negedge clk);
        end
        check("held_accepts", 32'(acc_n), 32'd2);
        check("held_second_accept", 32'(acc_second), 32'd5);
        check("held_rsp_pulses", 32'(rsp_n), 32'd2);
        check("held_rdata", 32'(rsp_rdata), 32'h00A5);

`ifdef SRAM_CTRL_READBACK_EN
        stuck0 = 1'b1;
        do_req(1'b1, 4'd9, 8'h01, 8'h00, 1'b1);
        stuck0 = 1'b0;
        do_req(1'b1, 4'd9, 8'h80, 8'h80, 1'b0);
`else
        do_req(1'b1, 4'd9, 8'h01, 8'hA5, 1'b0);
        do_req(1'b0, 4'd9, 8'h00, 8'h01, 1'b0);
`endif

        check("sequencing_violations", 32'(seq_viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
